// File: rtl/reg_writeback.sv
// Write-side sequencer between execute and the MSP430 register file: turns one
// retired result into auto-increment, destination and status-flag write cycles.
module reg_writeback #(
  parameter int SR_C_BIT = 0,
  parameter int SR_Z_BIT = 1,
  parameter int SR_N_BIT = 2,
  parameter int SR_V_BIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [15:0] result,
  input  logic [3:0]  dst,
  input  logic        bw,
  input  logic        dst_we,
  input  logic [3:0]  flags_in,
  input  logic [3:0]  flag_mask,
  input  logic        autoinc,
  input  logic [3:0]  inc_reg,
  input  logic [15:0] inc_base,
  input  logic [15:0] pc_next,
  input  logic [15:0] sp_cur,
  input  logic [15:0] sr_cur,
  output logic        RW,
  output logic [3:0]  DA,
  output logic [15:0] Din,
  output logic [15:0] PC_in,
  output logic [15:0] SP_in,
  output logic [15:0] SR_in,
  output logic        wb_done
);

  typedef enum logic [1:0] {IDLE, INC, WB, FLG} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_result;
  logic [3:0]  r_dst;
  logic        r_bw;
  logic        r_dstWe;
  logic [3:0]  r_flags;
  logic [3:0]  r_mask;
  logic [3:0]  r_incReg;
  logic [15:0] r_incBase;
  logic [15:0] r_sr;

  logic        w_accept;
  logic        w_doInc;
  logic        w_srWrite;
  logic        w_toFlg;
  logic [15:0] w_value;
  logic [15:0] w_incValue;
  logic [15:0] w_srNew;

  assign wb_ready = (r_state == IDLE) && !rst;
  assign w_accept = wb_valid && wb_ready;

  // R0 is advanced by fetch and R2/R3 are constant generators, so no INC cycle.
  assign w_doInc    = autoinc && (inc_reg != 4'd0) && (inc_reg != 4'd2) && (inc_reg != 4'd3);
  assign w_value    = r_bw ? {8'h00, r_result[7:0]} : r_result;
  assign w_incValue = r_incBase + ((!r_bw || r_incReg == 4'd1) ? 16'd2 : 16'd1);
  assign w_srWrite  = r_dstWe && (r_dst == 4'd2);
  assign w_toFlg    = (r_mask != 4'd0) && !w_srWrite;

  always_comb begin
    w_srNew = r_sr;
    if (r_mask[0]) w_srNew[SR_C_BIT] = r_flags[0];
    if (r_mask[1]) w_srNew[SR_Z_BIT] = r_flags[1];
    if (r_mask[2]) w_srNew[SR_N_BIT] = r_flags[2];
    if (r_mask[3]) w_srNew[SR_V_BIT] = r_flags[3];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_doInc ? INC : WB;
      INC:     w_next = WB;
      WB:      w_next = w_toFlg ? FLG : IDLE;
      FLG:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_dst     <= '0;
      r_bw      <= 1'b0;
      r_dstWe   <= 1'b0;
      r_flags   <= '0;
      r_mask    <= '0;
      r_incReg  <= '0;
      r_incBase <= '0;
      r_sr      <= '0;
    end else if (w_accept) begin
      r_result  <= result;
      r_dst     <= dst;
      r_bw      <= bw;
      r_dstWe   <= dst_we;
      r_flags   <= flags_in;
      r_mask    <= flag_mask;
      r_incReg  <= inc_reg;
      r_incBase <= inc_base;
      r_sr      <= sr_cur;
    end
  end

  // Outputs are forced to defaults while rst is high so an aborted transaction writes nothing.
  always_comb begin
    RW      = 1'b0;
    DA      = 4'd0;
    Din     = 16'd0;
    PC_in   = pc_next;
    SP_in   = sp_cur;
    SR_in   = sr_cur;
    wb_done = 1'b0;
    if (!rst) begin
      case (r_state)
        INC: begin
          if (r_incReg == 4'd1) begin
            SP_in = w_incValue;
          end else begin
            RW  = 1'b1;
            DA  = r_incReg;
            Din = w_incValue;
          end
        end
        WB: begin
          wb_done = !w_toFlg;
          if (r_dstWe) begin
            case (r_dst)
              4'd0: PC_in = {w_value[15:1], 1'b0};
              4'd1: SP_in = w_value;
              4'd2: begin
                RW    = 1'b1;
                DA    = 4'd2;
                Din   = w_value;
                SR_in = w_value;
              end
              4'd3: ;
              default: begin
                RW  = 1'b1;
                DA  = r_dst;
                Din = w_value;
              end
            endcase
          end
        end
        FLG: begin
          RW      = 1'b1;
          DA      = 4'd2;
          Din     = w_srNew;
          SR_in   = w_srNew;
          wb_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed, table-driven bench for reg_writeback with hand-computed cycle-by-cycle
// expectations, plus hand-written reset sequences.
module tb_reg_writeback;

  localparam logic [15:0] PC_NEXT = 16'hC000;
  localparam logic [15:0] SP_CUR  = 16'h0A00;
  localparam int          NVEC    = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] result;
  logic [3:0]  dst;
  logic        bw;
  logic        dst_we;
  logic [3:0]  flags_in;
  logic [3:0]  flag_mask;
  logic        autoinc;
  logic [3:0]  inc_reg;
  logic [15:0] inc_base;
  logic [15:0] pc_next;
  logic [15:0] sp_cur;
  logic [15:0] sr_cur;
  logic        RW;
  logic [3:0]  DA;
  logic [15:0] Din;
  logic [15:0] PC_in;
  logic [15:0] SP_in;
  logic [15:0] SR_in;
  logic        wb_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]       result;
    logic [3:0]        dst;
    logic              bw;
    logic              dstWe;
    logic [3:0]        flags;
    logic [3:0]        mask;
    logic              autoinc;
    logic [3:0]        incReg;
    logic [15:0]       incBase;
    logic [15:0]       srCur;
    int                nCyc;
    logic [2:0]        rw;
    logic [2:0][3:0]   da;
    logic [2:0][15:0]  din;
    logic [2:0][15:0]  pcIn;
    logic [2:0][15:0]  spIn;
    logic [2:0][15:0]  srIn;
    logic [2:0]        done;
  } vec_t;

  vec_t vecs[NVEC];

  reg_writeback dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .result(result), .dst(dst), .bw(bw), .dst_we(dst_we),
    .flags_in(flags_in), .flag_mask(flag_mask), .autoinc(autoinc),
    .inc_reg(inc_reg), .inc_base(inc_base), .pc_next(pc_next),
    .sp_cur(sp_cur), .sr_cur(sr_cur), .RW(RW), .DA(DA), .Din(Din),
    .PC_in(PC_in), .SP_in(SP_in), .SR_in(SR_in), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setVec(input int i, input logic [15:0] res, input logic [3:0] d,
                        input logic b, input logic we, input logic [3:0] fl,
                        input logic [3:0] mk, input logic ai, input logic [3:0] ir,
                        input logic [15:0] ib, input logic [15:0] sr, input int n);
    vecs[i].result  = res;
    vecs[i].dst     = d;
    vecs[i].bw      = b;
    vecs[i].dstWe   = we;
    vecs[i].flags   = fl;
    vecs[i].mask    = mk;
    vecs[i].autoinc = ai;
    vecs[i].incReg  = ir;
    vecs[i].incBase = ib;
    vecs[i].srCur   = sr;
    vecs[i].nCyc    = n;
  endtask

  task automatic setCyc(input int i, input int c, input logic w, input logic [3:0] a,
                        input logic [15:0] dn, input logic [15:0] pc, input logic [15:0] sp,
                        input logic [15:0] sr, input logic dne);
    vecs[i].rw[c]   = w;
    vecs[i].da[c]   = a;
    vecs[i].din[c]  = dn;
    vecs[i].pcIn[c] = pc;
    vecs[i].spIn[c] = sp;
    vecs[i].srIn[c] = sr;
    vecs[i].done[c] = dne;
  endtask

  task automatic checkCycle(input string tag, input int i, input int c);
    checkOutput({tag, " RW"},      16'(RW),      16'(vecs[i].rw[c]));
    checkOutput({tag, " DA"},      16'(DA),      16'(vecs[i].da[c]));
    checkOutput({tag, " Din"},     Din,          vecs[i].din[c]);
    checkOutput({tag, " PC_in"},   PC_in,        vecs[i].pcIn[c]);
    checkOutput({tag, " SP_in"},   SP_in,        vecs[i].spIn[c]);
    checkOutput({tag, " SR_in"},   SR_in,        vecs[i].srIn[c]);
    checkOutput({tag, " wb_done"}, 16'(wb_done), 16'(vecs[i].done[c]));
    checkOutput({tag, " wb_ready"}, 16'(wb_ready), 16'd0);
  endtask

  // Waits (bounded) for ready, then offers one vector at a negedge so it is accepted on the next posedge.
  task automatic offerVector(input int i);
    int waitCyc = 0;
    while (!wb_ready && waitCyc < 10) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput($sformatf("v%0d ready before accept", i), 16'(wb_ready), 16'd1);
    result    = vecs[i].result;
    dst       = vecs[i].dst;
    bw        = vecs[i].bw;
    dst_we    = vecs[i].dstWe;
    flags_in  = vecs[i].flags;
    flag_mask = vecs[i].mask;
    autoinc   = vecs[i].autoinc;
    inc_reg   = vecs[i].incReg;
    inc_base  = vecs[i].incBase;
    sr_cur    = vecs[i].srCur;
    wb_valid  = 1'b1;
    @(posedge clk);
    #1 wb_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int i);
    @(negedge clk);
    offerVector(i);
    for (int c = 0; c < vecs[i].nCyc; c++) begin
      @(negedge clk);
      checkCycle($sformatf("v%0d c%0d", i, c), i, c);
    end
    @(negedge clk);
    checkOutput($sformatf("v%0d ready after", i), 16'(wb_ready), 16'd1);
    checkOutput($sformatf("v%0d RW after", i), 16'(RW), 16'd0);
    checkOutput($sformatf("v%0d done after", i), 16'(wb_done), 16'd0);
  endtask

  initial begin
    // Plain ALU op to R5.
    setVec(0, 16'h1234, 4'd5, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1);
    setCyc(0, 0, 1'b1, 4'd5, 16'h1234, PC_NEXT, SP_CUR, 16'h0000, 1'b1);
    // Byte op with all flags updated.
    setVec(1, 16'hAB80, 4'd4, 1'b1, 1'b1, 4'b0100, 4'b1111, 1'b0, 4'd0, 16'h0000, 16'h0103, 2);
    setCyc(1, 0, 1'b1, 4'd4, 16'h0080, PC_NEXT, SP_CUR, 16'h0103, 1'b0);
    setCyc(1, 1, 1'b1, 4'd2, 16'h0004, PC_NEXT, SP_CUR, 16'h0004, 1'b1);
    // Auto-increment of R6 followed by a write to R6: WB wins.
    setVec(2, 16'h5555, 4'd6, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'd6, 16'h0200, 16'h0000, 2);
    setCyc(2, 0, 1'b1, 4'd6, 16'h0202, PC_NEXT, SP_CUR, 16'h0000, 1'b0);
    setCyc(2, 1, 1'b1, 4'd6, 16'h5555, PC_NEXT, SP_CUR, 16'h0000, 1'b1);
    // Write to PC drops bit 0.
    setVec(3, 16'h4401, 4'd0, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1);
    setCyc(3, 0, 1'b0, 4'd0, 16'h0000, 16'h4400, SP_CUR, 16'h0000, 1'b1);
    // Byte auto-increment of SP still steps by 2, then byte write to SP.
    setVec(4, 16'h1277, 4'd1, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'd1, 16'h03FE, 16'h0000, 2);
    setCyc(4, 0, 1'b0, 4'd0, 16'h0000, PC_NEXT, 16'h0400, 16'h0000, 1'b0);
    setCyc(4, 1, 1'b0, 4'd0, 16'h0000, PC_NEXT, 16'h0077, 16'h0000, 1'b1);
    // R3 destination is discarded.
    setVec(5, 16'hFFFF, 4'd3, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1);
    setCyc(5, 0, 1'b0, 4'd0, 16'h0000, PC_NEXT, SP_CUR, 16'h0000, 1'b1);
    // CMP-style: no dst write, flags only.
    setVec(6, 16'h9999, 4'd7, 1'b0, 1'b0, 4'b0010, 4'b0011, 1'b0, 4'd0, 16'h0000, 16'h0001, 2);
    setCyc(6, 0, 1'b0, 4'd0, 16'h0000, PC_NEXT, SP_CUR, 16'h0001, 1'b0);
    setCyc(6, 1, 1'b1, 4'd2, 16'h0002, PC_NEXT, SP_CUR, 16'h0002, 1'b1);
    // Explicit SR write suppresses the flag cycle.
    setVec(7, 16'h0008, 4'd2, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b0, 4'd0, 16'h0000, 16'h0000, 1);
    setCyc(7, 0, 1'b1, 4'd2, 16'h0008, PC_NEXT, SP_CUR, 16'h0008, 1'b1);
    // Auto-increment on constant generator R3 is skipped.
    setVec(8, 16'h00FF, 4'd9, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 4'd3, 16'h0010, 16'h0000, 1);
    setCyc(8, 0, 1'b1, 4'd9, 16'h00FF, PC_NEXT, SP_CUR, 16'h0000, 1'b1);
    // Full transaction: byte increment wraps, byte write, C and V set.
    setVec(9, 16'h8000, 4'd12, 1'b1, 1'b1, 4'b1001, 4'b1001, 1'b1, 4'd10, 16'hFFFF, 16'h0006, 3);
    setCyc(9, 0, 1'b1, 4'd10, 16'h0000, PC_NEXT, SP_CUR, 16'h0006, 1'b0);
    setCyc(9, 1, 1'b1, 4'd12, 16'h0000, PC_NEXT, SP_CUR, 16'h0006, 1'b0);
    setCyc(9, 2, 1'b1, 4'd2, 16'h0107, PC_NEXT, SP_CUR, 16'h0107, 1'b1);

    rst = 1'b1; wb_valid = 1'b0; result = '0; dst = '0; bw = 1'b0; dst_we = 1'b0;
    flags_in = '0; flag_mask = '0; autoinc = 1'b0; inc_reg = '0; inc_base = '0;
    pc_next = PC_NEXT; sp_cur = SP_CUR; sr_cur = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset RW", 16'(RW), 16'd0);
    checkOutput("reset wb_ready", 16'(wb_ready), 16'd0);
    checkOutput("reset wb_done", 16'(wb_done), 16'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset wb_ready", 16'(wb_ready), 16'd1);
    checkOutput("post-reset PC_in", PC_in, PC_NEXT);
    checkOutput("post-reset SP_in", SP_in, SP_CUR);

    for (int i = 0; i < NVEC; i++) applyStimulus(i);

    // Reset asserted during the INC cycle aborts the transaction.
    setVec(0, 16'h7777, 4'd5, 1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1, 4'd6, 16'h0100, 16'h0000, 1);
    @(negedge clk);
    offerVector(0);
    @(negedge clk);
    checkOutput("abort INC RW", 16'(RW), 16'd1);
    checkOutput("abort INC DA", 16'(DA), 16'd6);
    checkOutput("abort INC Din", Din, 16'h0102);
    rst = 1'b1;
    #1;
    checkOutput("abort rst RW", 16'(RW), 16'd0);
    checkOutput("abort rst ready", 16'(wb_ready), 16'd0);
    checkOutput("abort rst done", 16'(wb_done), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort after RW", 16'(RW), 16'd0);
    checkOutput("abort after done", 16'(wb_done), 16'd0);
    checkOutput("abort after ready", 16'(wb_ready), 16'd1);
    @(negedge clk);
    checkOutput("abort idle RW", 16'(RW), 16'd0);

    // A fresh transaction after the abort behaves normally.
    setVec(0, 16'h1234, 4'd5, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'd0, 16'h0000, 16'h0000, 1);
    applyStimulus(0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
